// File: rtl/regfile_pkg.sv
// Shared types and defaults for the scoreboarded register file.
package regfile_pkg;

    localparam int DEF_DATA_W    = 16;
    localparam int DEF_REG_COUNT = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    function automatic int addr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/regfile_rdport.sv
// One read port: register select, same-cycle write forwarding and busy masking.
module regfile_rdport
    import regfile_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int REG_COUNT = DEF_REG_COUNT,
    parameter int ADDR_W    = addr_width(DEF_REG_COUNT),
    parameter int ZERO_REG  = 0,
    parameter int BYPASS    = 1
) (
    input  logic [ADDR_W-1:0]                   src,
    input  logic [REG_COUNT-1:0][DATA_W-1:0]    reg_file,
    input  logic [REG_COUNT-1:0]                busy_vec,
    input  logic                                wr_fwd,
    input  logic [ADDR_W-1:0]                   dest,
    input  logic [DATA_W-1:0]                   w_in,
    output logic [DATA_W-1:0]                   op,
    output logic                                busy
);

    logic src_valid;

    // Out-of-range and hard-wired-zero addresses read as an idle zero.
    assign src_valid = (int'(src) < REG_COUNT) && !((ZERO_REG != 0) && (src == '0));

    always_comb begin
        op   = '0;
        busy = 1'b0;
        if (src_valid) begin
            if ((BYPASS != 0) && wr_fwd && (dest == src)) begin
                op   = w_in;
                busy = 1'b0;
            end else begin
                op   = reg_file[src];
                busy = busy_vec[src];
            end
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// Two-read/one-write register file with per-register busy bits and a clear sweep.
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int DATA_W    = DEF_DATA_W,
    parameter int REG_COUNT = DEF_REG_COUNT,
    parameter int ZERO_REG  = 0,
    parameter int BYPASS    = 1,
    parameter int ADDR_W    = addr_width(REG_COUNT)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [ADDR_W-1:0]   dest,
    input  logic [DATA_W-1:0]   w_in,
    input  logic                w_en,
    input  logic [ADDR_W-1:0]   src0,
    input  logic [ADDR_W-1:0]   src1,
    output logic [DATA_W-1:0]   op0,
    output logic [DATA_W-1:0]   op1,
    input  logic                issue_en,
    input  logic [ADDR_W-1:0]   issue_dest,
    output logic                src0_busy,
    output logic                src1_busy,
    input  logic                clear_req,
    output logic                ready
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(REG_COUNT - 1);

    state_t                             state_reg, state_next;
    logic [ADDR_W-1:0]                  idx_reg, idx_next;
    logic [REG_COUNT-1:0][DATA_W-1:0]   regs_reg;
    logic [REG_COUNT-1:0]               busy_reg;

    logic wr_ok, iss_ok;
    logic dest_ok, issue_ok_addr;

    assign dest_ok       = (int'(dest) < REG_COUNT) && !((ZERO_REG != 0) && (dest == '0));
    assign issue_ok_addr = (int'(issue_dest) < REG_COUNT) && !((ZERO_REG != 0) && (issue_dest == '0));

    // A clear request wins the cycle: any write or issue alongside it is dropped.
    assign wr_ok  = ready && w_en && !clear_req && dest_ok;
    assign iss_ok = ready && issue_en && !clear_req && issue_ok_addr;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_reg <= IDLE;
            idx_reg   <= '0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        case (state_reg)
            IDLE: begin
                if (clear_req) begin
                    state_next = CLEAR;
                    idx_next   = '0;
                end
            end
            CLEAR: begin
                if (idx_reg == LAST_IDX) begin
                    state_next = IDLE;
                    idx_next   = '0;
                end else begin
                    idx_next = idx_reg + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
                idx_next   = '0;
            end
        endcase
    end

    always_comb begin
        ready = (state_reg == IDLE);
    end

    // Issue is applied after the write so a same-register collision leaves busy set.
    always_ff @(posedge clk) begin
        if (!reset) begin
            regs_reg <= '0;
            busy_reg <= '0;
        end else if (state_reg == CLEAR) begin
            regs_reg[idx_reg] <= '0;
            busy_reg[idx_reg] <= 1'b0;
        end else begin
            if (wr_ok) begin
                regs_reg[dest] <= w_in;
                busy_reg[dest] <= 1'b0;
            end
            if (iss_ok) begin
                busy_reg[issue_dest] <= 1'b1;
            end
        end
    end

    logic [1:0][ADDR_W-1:0] src_arr;
    logic [1:0][DATA_W-1:0] op_arr;
    logic [1:0]             busy_arr;

    assign src_arr[0] = src0;
    assign src_arr[1] = src1;
    assign op0        = op_arr[0];
    assign op1        = op_arr[1];
    assign src0_busy  = busy_arr[0];
    assign src1_busy  = busy_arr[1];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_rdport
            regfile_rdport #(
                .DATA_W    (DATA_W),
                .REG_COUNT (REG_COUNT),
                .ADDR_W    (ADDR_W),
                .ZERO_REG  (ZERO_REG),
                .BYPASS    (BYPASS)
            ) u_rdport (
                .src      (src_arr[gi]),
                .reg_file (regs_reg),
                .busy_vec (busy_reg),
                .wr_fwd   (wr_ok),
                .dest     (dest),
                .w_in     (w_in),
                .op       (op_arr[gi]),
                .busy     (busy_arr[gi])
            );
        end
    endgenerate

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench: default file plus a ZERO_REG=1 copy driven by the same inputs.
module tb_regfile_sb;

    logic        clk;
    logic        reset;
    logic [2:0]  dest, src0, src1, issue_dest;
    logic [15:0] w_in;
    logic        w_en, issue_en, clear_req;

    logic [15:0] op0, op1, op0_z, op1_z;
    logic        src0_busy, src1_busy, ready;
    logic        src0_busy_z, src1_busy_z, ready_z;

    int n_checks = 0;
    int n_fail   = 0;

    regfile_sb dut (
        .clk(clk), .reset(reset), .dest(dest), .w_in(w_in), .w_en(w_en),
        .src0(src0), .src1(src1), .op0(op0), .op1(op1),
        .issue_en(issue_en), .issue_dest(issue_dest),
        .src0_busy(src0_busy), .src1_busy(src1_busy),
        .clear_req(clear_req), .ready(ready)
    );

    regfile_sb #(.ZERO_REG(1)) dut_z (
        .clk(clk), .reset(reset), .dest(dest), .w_in(w_in), .w_en(w_en),
        .src0(src0), .src1(src1), .op0(op0_z), .op1(op1_z),
        .issue_en(issue_en), .issue_dest(issue_dest),
        .src0_busy(src0_busy_z), .src1_busy(src1_busy_z),
        .clear_req(clear_req), .ready(ready_z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        w_en = 1'b0; issue_en = 1'b0; clear_req = 1'b0;
        dest = '0; w_in = '0; issue_dest = '0;
    endtask

    int cycles;

    initial begin
        idle_inputs();
        src0 = 3'd1; src1 = 3'd2;
        reset = 1'b0;
        step(); step();
        reset = 1'b1;
        #1;
        check("reset_ready",  32'(ready), 32'd1);
        check("reset_op0",    32'(op0), 32'h0);
        check("reset_op1",    32'(op1), 32'h0);
        check("reset_busy0",  32'(src0_busy), 32'd0);
        check("reset_busy1",  32'(src1_busy), 32'd0);

        // Plain write then read-back; disabled write leaves r2 alone.
        src0 = 3'd0;
        w_en = 1'b1; dest = 3'd1; w_in = 16'hAAAA;
        step();
        w_en = 1'b0; dest = 3'd2; w_in = 16'h5555;
        src0 = 3'd1;
        step();
        src1 = 3'd2;
        #1;
        check("write_r1_op0", 32'(op0), 32'hAAAA);
        check("nowrite_r2",   32'(op1), 32'h0);

        // Reserve r3, then bypass a write to it: forwarded data and busy masked.
        issue_en = 1'b1; issue_dest = 3'd3;
        step();
        issue_en = 1'b0;
        src1 = 3'd3;
        #1;
        check("issue_r3_busy", 32'(src1_busy), 32'd1);
        w_en = 1'b1; dest = 3'd3; w_in = 16'hCCCC;
        #1;
        check("bypass_op1",   32'(op1), 32'hCCCC);
        check("bypass_busy1", 32'(src1_busy), 32'd0);
        step();
        w_en = 1'b0;
        #1;
        check("r3_stored",    32'(op1), 32'hCCCC);
        check("r3_busy_clr",  32'(src1_busy), 32'd0);

        // Issue r4, then retire it with a write.
        issue_en = 1'b1; issue_dest = 3'd4;
        step();
        issue_en = 1'b0;
        src0 = 3'd4;
        #1;
        check("issue_r4_busy", 32'(src0_busy), 32'd1);
        check("issue_r4_op0",  32'(op0), 32'h0);
        src0 = 3'd5;
        w_en = 1'b1; dest = 3'd4; w_in = 16'hDDDD;
        step();
        w_en = 1'b0;
        src0 = 3'd4;
        #1;
        check("r4_busy_clr", 32'(src0_busy), 32'd0);
        check("r4_op0",      32'(op0), 32'hDDDD);

        // Write and issue collide on r5: data lands, busy stays set.
        src0 = 3'd0;
        w_en = 1'b1; dest = 3'd5; w_in = 16'hEEEE;
        issue_en = 1'b1; issue_dest = 3'd5;
        step();
        idle_inputs();
        src0 = 3'd5;
        #1;
        check("r5_op0",  32'(op0), 32'hEEEE);
        check("r5_busy", 32'(src0_busy), 32'd1);

        // Zero register: r0 write is visible only in the default file.
        src1 = 3'd7;
        w_en = 1'b1; dest = 3'd0; w_in = 16'h1234;
        step();
        w_en = 1'b0;
        issue_en = 1'b1; issue_dest = 3'd0;
        step();
        issue_en = 1'b0;
        src0 = 3'd0;
        #1;
        check("r0_plain_op0",  32'(op0), 32'h1234);
        check("r0_zero_op0",   32'(op0_z), 32'h0);
        check("r0_zero_busy",  32'(src0_busy_z), 32'd0);
        check("r0_plain_busy", 32'(src0_busy), 32'd1);

        // Fill every register, then sweep.
        for (int i = 0; i < 8; i++) begin
            w_en = 1'b1; dest = 3'(i); w_in = 16'hFFFF;
            step();
        end
        w_en = 1'b0;
        src0 = 3'd7;
        #1;
        check("fill_r7", 32'(op0), 32'hFFFF);

        // Write and issue alongside the request must be dropped.
        clear_req = 1'b1;
        w_en = 1'b1; dest = 3'd2; w_in = 16'h1111;
        issue_en = 1'b1; issue_dest = 3'd2;
        step();
        clear_req = 1'b0; issue_en = 1'b0;
        w_en = 1'b1; dest = 3'd6; w_in = 16'h7777;
        cycles = 0;
        while (!ready && cycles < 20) begin
            cycles++;
            step();
        end
        idle_inputs();
        check("clear_cycles", 32'(cycles), 32'd8);
        for (int i = 0; i < 8; i++) begin
            src0 = 3'(i);
            #1;
            check($sformatf("clear_r%0d_op", i), 32'(op0), 32'h0);
            check($sformatf("clear_r%0d_busy", i), 32'(src0_busy), 32'd0);
        end

        // Reset in the middle of a sweep.
        issue_en = 1'b1; issue_dest = 3'd2;
        step();
        issue_en = 1'b0;
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        step(); step();
        check("midsweep_ready_low", 32'(ready_z), 32'd0);
        reset = 1'b0;
        step();
        reset = 1'b1;
        src0 = 3'd2;
        #1;
        check("midsweep_ready",   32'(ready_z), 32'd1);
        check("midsweep_ready_d", 32'(ready), 32'd1);
        check("midsweep_busy2",   32'(src0_busy), 32'd0);
        step();
        check("post_reset_ready", 32'(ready), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
